dmem_port_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the core load/store unit, port 1 is a debug/DMA master.
- Sits between both requesters and the data memory. It registers the winning request, sequences the memory cycle (chip-select, write-enable, byte mask, address, write data), waits the memory read latency, then returns read data with a one-cycle ack.
- Produces the core stall while the core's access is pending.

---
 rtl/dmem_port_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-port data memory between the core load/store unit
//   (port 0) and a debug/DMA master (port 1). A winning request is
//   registered, driven onto the memory for one cycle, and, for a load,
//   followed by LOAD_LAT-cycle wait before the read data is captured. Each
//   transaction ends with a one-cycle ack on the winning port.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   reqN, wrN, maskN, addrN,  requester N: request valid, write-enable
//   wdataN                    (active-low), byte mask, address, store data
//   ackN, rdataN              one-cycle completion pulse, last load word
//   stall                     core stall: req0 & ~ack0 (combinational)
//   cs, wr, mask, addr,       memory chip-select (active-low), write-enable
//   data_wr                   (active-low), byte-write mask, address, write data
//   data_rd                   memory read data

module dmem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0,
    input  logic                wr0,
    input  logic [DATA_W/8-1:0] mask0,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [DATA_W-1:0]   wdata0,
    output logic                ack0,
    output logic [DATA_W-1:0]   rdata0,
    output logic                stall,

    input  logic                req1,
    input  logic                wr1,
    input  logic [DATA_W/8-1:0] mask1,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata1,
    output logic                ack1,
    output logic [DATA_W-1:0]   rdata1,

    output logic                cs,
    output logic                wr,
    output logic [DATA_W/8-1:0] mask,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   data_wr,
    input  logic [DATA_W-1:0]   data_rd
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LOAD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                r_is_load,    w_is_load_nxt;
    logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
    logic                r_cs,         w_cs_nxt;
    logic                r_wr,         w_wr_nxt;
    logic [MASK_W-1:0]   r_mask,       w_mask_nxt;
    logic [ADDR_W-1:0]   r_addr,       w_addr_nxt;
    logic [DATA_W-1:0]   r_data_wr,    w_data_wr_nxt;
    logic                r_ack0,       w_ack0_nxt;
    logic                r_ack1,       w_ack1_nxt;
    logic [DATA_W-1:0]   r_rdata0,     w_rdata0_nxt;
    logic [DATA_W-1:0]   r_rdata1,     w_rdata1_nxt;

    // Winner selection: sole requester wins, a tie goes to the port not granted last.
    logic                w_winner;
    logic                w_sel_wr;
    logic [MASK_W-1:0]   w_sel_mask;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    always_comb begin
        w_winner    = (req0 && req1) ? ~r_last_grant : req1;
        w_sel_wr    = w_winner ? wr1    : wr0;
        w_sel_mask  = w_winner ? mask1  : mask0;
        w_sel_addr  = w_winner ? addr1  : addr0;
        w_sel_wdata = w_winner ? wdata1 : wdata0;
    end

    // Next-state and next-output logic. Memory outputs are registered, so the
    // values seen during ISSUE are loaded on the IDLE->ISSUE transition.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_is_load_nxt    = r_is_load;
        w_cnt_nxt        = r_cnt;
        w_cs_nxt         = 1'b1;
        w_wr_nxt         = 1'b1;
        w_mask_nxt       = '0;
        w_addr_nxt       = r_addr;
        w_data_wr_nxt    = r_data_wr;
        w_ack0_nxt       = 1'b0;
        w_ack1_nxt       = 1'b0;
        w_rdata0_nxt     = r_rdata0;
        w_rdata1_nxt     = r_rdata1;

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt      = S_ISSUE;
                    w_last_grant_nxt = w_winner;
                    w_is_load_nxt    = w_sel_wr;
                    w_cs_nxt         = 1'b0;
                    w_wr_nxt         = w_sel_wr;
                    // Loads never assert byte-write lanes.
                    w_mask_nxt       = w_sel_wr ? '0 : w_sel_mask;
                    w_addr_nxt       = w_sel_addr;
                    w_data_wr_nxt    = w_sel_wdata;
                end
            end
            S_ISSUE: begin
                if (r_is_load) begin
                    w_cnt_nxt   = LAT_INIT;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_DONE;
                    w_ack0_nxt  = ~r_last_grant;
                    w_ack1_nxt  = r_last_grant;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_ack0_nxt  = ~r_last_grant;
                    w_ack1_nxt  = r_last_grant;
                    if (r_last_grant) begin
                        w_rdata1_nxt = data_rd;
                    end else begin
                        w_rdata0_nxt = data_rd;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_is_load    <= 1'b0;
            r_cnt        <= '0;
            r_cs         <= 1'b1;
            r_wr         <= 1'b1;
            r_mask       <= '0;
            r_addr       <= '0;
            r_data_wr    <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_is_load    <= w_is_load_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cs         <= w_cs_nxt;
            r_wr         <= w_wr_nxt;
            r_mask       <= w_mask_nxt;
            r_addr       <= w_addr_nxt;
            r_data_wr    <= w_data_wr_nxt;
            r_ack0       <= w_ack0_nxt;
            r_ack1       <= w_ack1_nxt;
            r_rdata0     <= w_rdata0_nxt;
            r_rdata1     <= w_rdata1_nxt;
        end
    end

    assign cs      = r_cs;
    assign wr      = r_wr;
    assign mask    = r_mask;
    assign addr    = r_addr;
    assign data_wr = r_data_wr;
    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign stall   = req0 & ~r_ack0;

endmodule
